// File: rtl/vga_timing_pkg.sv
// Shared constants, lock-FSM state encoding and counter helpers for the VGA timing detector.
package vga_timing_pkg;

    localparam int   PW_DEF     = 14;
    localparam int   VW         = 12;
    localparam logic HS_ACT_DEF = 1'b0;
    localparam logic VS_ACT_DEF = 1'b0;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_CHECK   = 2'd2,
        ST_LOCKED  = 2'd3
    } state_e;

    // Vertical counters stick at all-ones rather than wrapping on absurd input.
    function automatic logic [VW-1:0] sat_inc_v(input logic [VW-1:0] v);
        return (v == {VW{1'b1}}) ? v : v + VW'(1);
    endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Single input register stage for hs/vs/de/valid, plus one cycle of history to form edge pulses.
module vga_sync_edge
    import vga_timing_pkg::*;
#(
    parameter logic HS_ACT = HS_ACT_DEF,
    parameter logic VS_ACT = VS_ACT_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic hs_i,
    input  logic vs_i,
    input  logic de_i,
    input  logic vld_i,
    output logic vld_o,
    output logic hs_edge_o,
    output logic vs_edge_o,
    output logic de_rise_o,
    output logic de_fall_o
);

    logic hs_q, vs_q, de_q, vld_q;
    logic hs_p_q, vs_p_q, de_p_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hs_q   <= ~HS_ACT;
            vs_q   <= ~VS_ACT;
            de_q   <= 1'b0;
            vld_q  <= 1'b0;
            hs_p_q <= ~HS_ACT;
            vs_p_q <= ~VS_ACT;
            de_p_q <= 1'b0;
        end else begin
            hs_q   <= hs_i;
            vs_q   <= vs_i;
            de_q   <= de_i;
            vld_q  <= vld_i & de_i;
            hs_p_q <= hs_q;
            vs_p_q <= vs_q;
            de_p_q <= de_q;
        end
    end

    assign vld_o     = vld_q;
    assign hs_edge_o = (hs_q == HS_ACT) && (hs_p_q != HS_ACT);
    assign vs_edge_o = (vs_q == VS_ACT) && (vs_p_q != VS_ACT);
    assign de_rise_o = de_q & ~de_p_q;
    assign de_fall_o = ~de_q & de_p_q;

endmodule

// File: rtl/vga_timing_det.sv
// Measures incoming video timing, tracks the active pixel position and locks once two frames agree.
module vga_timing_det
    import vga_timing_pkg::*;
#(
    parameter int   PW     = PW_DEF,
    parameter logic HS_ACT = HS_ACT_DEF,
    parameter logic VS_ACT = VS_ACT_DEF
) (
    input  logic          in_pclk,
    input  logic          in_rstn,
    input  logic          in_de,
    input  logic          in_hs,
    input  logic          in_vs,
    input  logic          in_valid,
    output logic [PW-1:0] out_x,
    output logic [VW-1:0] out_y,
    output logic          out_valid,
    output logic          out_sof,
    output logic [PW-1:0] out_h_total,
    output logic [PW-1:0] out_h_active,
    output logic [VW-1:0] out_v_total,
    output logic [VW-1:0] out_v_active,
    output logic          out_locked,
    output logic          out_err
);

    localparam logic [PW-1:0] PW_MAX = {PW{1'b1}};
    localparam logic [PW-1:0] PW_ONE = PW'(1);

    logic vld_s, hs_edge, vs_edge, de_rise, de_fall;

    logic [PW-1:0] h_cnt_q, h_cnt_d, line_len_q, line_len_d;
    logic [PW-1:0] px_cnt_q, px_cnt_d, line_act_q, line_act_d, xcur;
    logic [VW-1:0] ln_cnt_q, ln_cnt_d, act_cnt_q, act_cnt_d, f_act;
    logic [PW-1:0] x_q, h_tot_q, h_act_q;
    logic [VW-1:0] y_q, v_tot_q, v_act_q;
    logic          valid_q, sof_q, err_q, err_d, store, match;
    state_e        state_q, state_d;

    vga_sync_edge #(
        .HS_ACT (HS_ACT),
        .VS_ACT (VS_ACT)
    ) u_sync (
        .clk_i     (in_pclk),
        .rst_ni    (in_rstn),
        .hs_i      (in_hs),
        .vs_i      (in_vs),
        .de_i      (in_de),
        .vld_i     (in_valid),
        .vld_o     (vld_s),
        .hs_edge_o (hs_edge),
        .vs_edge_o (vs_edge),
        .de_rise_o (de_rise),
        .de_fall_o (de_fall)
    );

    always_comb begin
        h_cnt_d    = (h_cnt_q == PW_MAX) ? h_cnt_q : h_cnt_q + PW_ONE;
        line_len_d = line_len_q;
        if (hs_edge) begin
            h_cnt_d    = '0;
            line_len_d = (h_cnt_q == PW_MAX) ? PW_MAX : h_cnt_q + PW_ONE;
        end

        // The first pixel can land on the same cycle as DE rise, so clear before counting.
        xcur     = de_rise ? '0 : px_cnt_q;
        px_cnt_d = xcur;
        if (vld_s && xcur != PW_MAX) begin
            px_cnt_d = xcur + PW_ONE;
        end
        line_act_d = de_fall ? px_cnt_q : line_act_q;

        ln_cnt_d = hs_edge ? sat_inc_v(ln_cnt_q) : ln_cnt_q;
        if (vs_edge) begin
            ln_cnt_d = hs_edge ? VW'(1) : '0;
        end
        f_act     = de_fall ? sat_inc_v(act_cnt_q) : act_cnt_q;
        act_cnt_d = vs_edge ? '0 : f_act;
    end

    // Frame snapshot taken at VS: the HS edge of this cycle belongs to the new frame,
    // while a coincident DE fall still belongs to the frame that is ending.
    assign match = (line_len_d == h_tot_q) && (line_act_d == h_act_q) &&
                   (ln_cnt_q == v_tot_q) && (f_act == v_act_q);

    always_comb begin
        state_d = state_q;
        store   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_SEARCH: begin
                if (vs_edge) state_d = ST_MEASURE;
            end
            ST_MEASURE: begin
                if (vs_edge) begin
                    state_d = ST_CHECK;
                    store   = 1'b1;
                end
            end
            ST_CHECK: begin
                if (vs_edge) begin
                    store = 1'b1;
                    if (match) state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (vs_edge) begin
                    if (!match) begin
                        state_d = ST_CHECK;
                        store   = 1'b1;
                        err_d   = 1'b1;
                    end
                end else if (de_fall && px_cnt_q != h_act_q) begin
                    state_d = ST_CHECK;
                    err_d   = 1'b1;
                end
            end
            default: state_d = ST_SEARCH;
        endcase
    end

    always_ff @(posedge in_pclk or negedge in_rstn) begin
        if (!in_rstn) begin
            h_cnt_q    <= '0;
            line_len_q <= '0;
            px_cnt_q   <= '0;
            line_act_q <= '0;
            ln_cnt_q   <= '0;
            act_cnt_q  <= '0;
            x_q        <= '0;
            y_q        <= '0;
            valid_q    <= 1'b0;
            sof_q      <= 1'b0;
            err_q      <= 1'b0;
            h_tot_q    <= '0;
            h_act_q    <= '0;
            v_tot_q    <= '0;
            v_act_q    <= '0;
            state_q    <= ST_SEARCH;
        end else begin
            h_cnt_q    <= h_cnt_d;
            line_len_q <= line_len_d;
            px_cnt_q   <= px_cnt_d;
            line_act_q <= line_act_d;
            ln_cnt_q   <= ln_cnt_d;
            act_cnt_q  <= act_cnt_d;
            valid_q    <= vld_s;
            if (vld_s) begin
                x_q <= xcur;
                y_q <= act_cnt_q;
            end
            sof_q   <= vld_s && (xcur == '0) && (act_cnt_q == '0);
            err_q   <= err_d;
            state_q <= state_d;
            if (store) begin
                h_tot_q <= line_len_d;
                h_act_q <= line_act_d;
                v_tot_q <= ln_cnt_q;
                v_act_q <= f_act;
            end
        end
    end

    assign out_x        = x_q;
    assign out_y        = y_q;
    assign out_valid    = valid_q;
    assign out_sof      = sof_q;
    assign out_err      = err_q;
    assign out_h_total  = h_tot_q;
    assign out_h_active = h_act_q;
    assign out_v_total  = v_tot_q;
    assign out_v_active = v_act_q;
    assign out_locked   = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_vga_timing_det.sv
// [TB] Self-checking bench for vga_timing_det using a reduced raster (40x12 clocks, 32x8 active).
module tb_vga_timing_det;

    localparam int   PW    = 14;
    localparam int   H_TOT = 40;
    localparam int   H_ACT = 32;
    localparam int   HSW   = 4;
    localparam int   V_TOT = 12;
    localparam int   V_ACT = 8;
    localparam logic HS_A  = 1'b0;
    localparam logic VS_A  = 1'b0;

    typedef struct {
        logic [PW-1:0] x;
        logic [11:0]   y;
        int            due;
    } exp_t;

    logic          clk = 1'b0;
    logic          rstN = 1'b0;
    logic          inDe = 1'b0, inHs = ~HS_A, inVs = ~VS_A, inValid = 1'b0;
    logic [PW-1:0] out_x, out_h_total, out_h_active;
    logic [11:0]   out_y, out_v_total, out_v_active;
    logic          out_valid, out_sof, out_locked, out_err;

    exp_t          sb[$];
    int            nVec = 0, nErr = 0, cyc = 0;
    int            frValid, frSof, frErr;
    bit            frUnlock;
    logic [PW-1:0] lastX;
    logic [11:0]   lastY;

    vga_timing_det #(.PW(PW), .HS_ACT(HS_A), .VS_ACT(VS_A)) dut (
        .in_pclk      (clk),
        .in_rstn      (rstN),
        .in_de        (inDe),
        .in_hs        (inHs),
        .in_vs        (inVs),
        .in_valid     (inValid),
        .out_x        (out_x),
        .out_y        (out_y),
        .out_valid    (out_valid),
        .out_sof      (out_sof),
        .out_h_total  (out_h_total),
        .out_h_active (out_h_active),
        .out_v_total  (out_v_total),
        .out_v_active (out_v_active),
        .out_locked   (out_locked),
        .out_err      (out_err)
    );

    always #5 clk = ~clk;

    // One clock of stimulus; outputs produced by earlier pixels are drained from the scoreboard first.
    task automatic step(input logic hs, input logic vs, input logic de, input logic vld,
                        input int px, input int ay);
        exp_t e;
        @(negedge clk);
        cyc++;
        if (out_valid) begin
            nVec++;
            frValid++;
            lastX = out_x;
            lastY = out_y;
            if (sb.size() == 0) begin
                nErr++;
                $display("[TB] FAIL sb_unexpected: out_valid=1 at cyc %0d, required no pixel", cyc);
            end else begin
                e = sb.pop_front();
                if (out_x !== e.x || out_y !== e.y || cyc != e.due ||
                    out_sof !== (e.x == 0 && e.y == 0)) begin
                    nErr++;
                    $display("[TB] FAIL sb_pixel: got x=%0d y=%0d cyc=%0d sof=%b, required x=%0d y=%0d cyc=%0d sof=%b",
                             out_x, out_y, cyc, out_sof, e.x, e.y, e.due, (e.x == 0 && e.y == 0));
                end
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            nVec++;
            nErr++;
            $display("[TB] FAIL sb_missing: no out_valid at cyc %0d, required x=%0d y=%0d",
                     cyc, sb[0].x, sb[0].y);
            void'(sb.pop_front());
        end
        if (out_sof && !out_valid) begin
            nVec++;
            nErr++;
            $display("[TB] FAIL sof_alone: out_sof=1 out_valid=0 at cyc %0d, required sof=0", cyc);
        end
        if (out_sof) frSof++;
        if (out_err) frErr++;
        if (!out_locked) frUnlock = 1'b1;
        inHs    = hs;
        inVs    = vs;
        inDe    = de;
        inValid = vld;
        if (de && vld) begin
            e.x   = PW'(px);
            e.y   = 12'(ay);
            e.due = cyc + 2;
            sb.push_back(e);
        end
    endtask

    task automatic run_frame(input int htot, input int pstep, input int firstLine, input int lastLine,
                             input bit coinc, input int dropLine);
        int   ay, px;
        logic de, vld, hs, vAct;
        frValid  = 0;
        frSof    = 0;
        frErr    = 0;
        frUnlock = 1'b0;
        ay       = 0;
        for (int ln = firstLine; ln < lastLine; ln++) begin
            px = 0;
            for (int c = 0; c < htot; c++) begin
                de  = (ln < V_ACT) && (c < H_ACT);
                vld = de && (c % pstep == 0) && !(ln == dropLine && c == 3);
                hs  = (c >= H_ACT + 2 && c < H_ACT + 2 + HSW) ? HS_A : ~HS_A;
                if (coinc)
                    vAct = (ln == V_ACT + 1 && c >= H_ACT + 2) || ln == V_ACT + 2 ||
                           (ln == V_ACT + 3 && c < H_ACT + 2);
                else
                    vAct = (ln == V_ACT + 1) || (ln == V_ACT + 2);
                step(hs, vAct ? VS_A : ~VS_A, de, vld, px, ay);
                if (vld) px++;
            end
            if (ln < V_ACT) ay++;
        end
    endtask

    task automatic do_reset;
        @(negedge clk);
        inHs    = ~HS_A;
        inVs    = ~VS_A;
        inDe    = 1'b0;
        inValid = 1'b0;
        rstN    = 1'b0;
        sb.delete();
        repeat (3) @(negedge clk);
        rstN = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        repeat (4) step(~HS_A, ~VS_A, 1'b0, 1'b0, 0, 0);
        nVec++;
        if ({out_valid, out_sof, out_err, out_locked} !== 4'b0) begin
            nErr++;
            $display("[TB] FAIL reset_flags: got valid/sof/err/locked=%b, required 0000",
                     {out_valid, out_sof, out_err, out_locked});
        end
        nVec++;
        if (out_x !== '0 || out_y !== '0) begin
            nErr++;
            $display("[TB] FAIL reset_xy: got x=%0d y=%0d, required 0 0", out_x, out_y);
        end
        nVec++;
        if (out_h_total !== '0 || out_h_active !== '0 || out_v_total !== '0 || out_v_active !== '0) begin
            nErr++;
            $display("[TB] FAIL reset_meas: got %0d %0d %0d %0d, required all 0",
                     out_h_total, out_h_active, out_v_total, out_v_active);
        end
    endtask

    task automatic test_lock;
        do_reset();
        for (int f = 1; f <= 3; f++) begin
            run_frame(H_TOT, 1, 0, V_TOT, 1'b0, -1);
            nVec++;
            if (frValid != H_ACT * V_ACT || frSof != 1) begin
                nErr++;
                $display("[TB] FAIL lock_counts f%0d: got valid=%0d sof=%0d, required %0d 1",
                         f, frValid, frSof, H_ACT * V_ACT);
            end
            nVec++;
            if (lastX !== PW'(H_ACT - 1) || lastY !== 12'(V_ACT - 1)) begin
                nErr++;
                $display("[TB] FAIL lock_last f%0d: got x=%0d y=%0d, required %0d %0d",
                         f, lastX, lastY, H_ACT - 1, V_ACT - 1);
            end
            nVec++;
            if (out_locked !== (f == 3)) begin
                nErr++;
                $display("[TB] FAIL lock_state f%0d: got %b, required %b", f, out_locked, (f == 3));
            end
        end
        nVec++;
        if (out_h_total !== PW'(H_TOT) || out_h_active !== PW'(H_ACT) ||
            out_v_total !== 12'(V_TOT) || out_v_active !== 12'(V_ACT)) begin
            nErr++;
            $display("[TB] FAIL lock_meas: got %0d %0d %0d %0d, required %0d %0d %0d %0d",
                     out_h_total, out_h_active, out_v_total, out_v_active, H_TOT, H_ACT, V_TOT, V_ACT);
        end
    endtask

    task automatic test_pcnt2;
        do_reset();
        repeat (3) run_frame(H_TOT, 2, 0, V_TOT, 1'b0, -1);
        nVec++;
        if (out_h_active !== PW'(H_ACT / 2) || out_locked !== 1'b1) begin
            nErr++;
            $display("[TB] FAIL pcnt2_meas: got h_active=%0d locked=%b, required %0d 1",
                     out_h_active, out_locked, H_ACT / 2);
        end
        nVec++;
        if (frValid != (H_ACT / 2) * V_ACT || lastX !== PW'(H_ACT / 2 - 1)) begin
            nErr++;
            $display("[TB] FAIL pcnt2_count: got valid=%0d lastx=%0d, required %0d %0d",
                     frValid, lastX, (H_ACT / 2) * V_ACT, H_ACT / 2 - 1);
        end
    endtask

    task automatic test_err_relock;
        do_reset();
        repeat (3) run_frame(H_TOT, 1, 0, V_TOT, 1'b0, -1);
        run_frame(H_TOT + 1, 1, 0, V_TOT, 1'b0, -1);
        nVec++;
        if (frErr != 1 || out_locked !== 1'b0 || out_h_total !== PW'(H_TOT + 1)) begin
            nErr++;
            $display("[TB] FAIL longline: got err=%0d locked=%b h_total=%0d, required 1 0 %0d",
                     frErr, out_locked, out_h_total, H_TOT + 1);
        end
        for (int f = 1; f <= 2; f++) begin
            run_frame(H_TOT, 1, 0, V_TOT, 1'b0, -1);
            nVec++;
            if (frErr != 0 || out_locked !== (f == 2) || out_h_total !== PW'(H_TOT)) begin
                nErr++;
                $display("[TB] FAIL relock f%0d: got err=%0d locked=%b h_total=%0d, required 0 %b %0d",
                         f, frErr, out_locked, out_h_total, (f == 2), H_TOT);
            end
        end
    endtask

    task automatic test_width_err;
        run_frame(H_TOT, 1, 0, V_TOT, 1'b0, 2);
        nVec++;
        if (frErr != 1 || !frUnlock || out_locked !== 1'b1 || out_h_active !== PW'(H_ACT)) begin
            nErr++;
            $display("[TB] FAIL width_err: got err=%0d unlocked=%b locked=%b h_active=%0d, required 1 1 1 %0d",
                     frErr, frUnlock, out_locked, out_h_active, H_ACT);
        end
    endtask

    task automatic test_reset_mid;
        nVec++;
        if (out_locked !== 1'b1) begin
            nErr++;
            $display("[TB] FAIL pre_reset_lock: got %b, required 1", out_locked);
        end
        run_frame(H_TOT, 1, 0, 4, 1'b0, -1);
        rstN = 1'b0;
        #1;
        nVec++;
        if (out_locked !== 1'b0 || out_h_total !== '0 || out_v_total !== '0 || out_valid !== 1'b0) begin
            nErr++;
            $display("[TB] FAIL reset_mid: got locked=%b h_total=%0d v_total=%0d valid=%b, required 0 0 0 0",
                     out_locked, out_h_total, out_v_total, out_valid);
        end
        sb.delete();
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        run_frame(H_TOT, 1, 4, V_TOT, 1'b0, -1);
        for (int f = 1; f <= 2; f++) begin
            run_frame(H_TOT, 1, 0, V_TOT, 1'b0, -1);
            nVec++;
            if (out_locked !== (f == 2)) begin
                nErr++;
                $display("[TB] FAIL reset_relock f%0d: got %b, required %b", f, out_locked, (f == 2));
            end
        end
    endtask

    task automatic test_vs_coinc;
        do_reset();
        repeat (3) run_frame(H_TOT, 1, 0, V_TOT, 1'b1, -1);
        nVec++;
        if (out_v_total !== 12'(V_TOT) || out_v_active !== 12'(V_ACT) || out_locked !== 1'b1) begin
            nErr++;
            $display("[TB] FAIL vs_coinc: got v_total=%0d v_active=%0d locked=%b, required %0d %0d 1",
                     out_v_total, out_v_active, out_locked, V_TOT, V_ACT);
        end
        nVec++;
        if (frSof != 1 || frValid != H_ACT * V_ACT) begin
            nErr++;
            $display("[TB] FAIL vs_coinc_px: got sof=%0d valid=%0d, required 1 %0d",
                     frSof, frValid, H_ACT * V_ACT);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_pcnt2();
        test_err_relock();
        test_width_err();
        test_reset_mid();
        test_vs_coinc();
        repeat (4) step(~HS_A, ~VS_A, 1'b0, 1'b0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
